tm_spi_sram_target: RTL and testbench

// SPI mode-0 target emulating a serial SRAM: READ 0x03 / WRITE 0x02, 16-bit address, sequential auto-increment.

---
 rtl/tm_spi_sram_target.sv | 203 ++++++++++++++++++++
 tb/tb_tm_spi_sram_target.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm_spi_sram_target.sv
// SPI mode-0 target emulating a serial SRAM (READ 0x03 / WRITE 0x02, 16-bit
// address, sequential auto-increment) backed by an internal byte array.
// A host port preloads and inspects the array while the SPI bus is idle.
//
// state     | meaning
// ST_IDLE   | CS inactive, waiting for a CS falling edge
// ST_CMD    | shifting in the command byte
// ST_ADRH   | shifting in the address high byte
// ST_ADRL   | shifting in the address low byte
// ST_RDATA  | streaming array bytes out on MISO
// ST_WDATA  | writing each completed MOSI byte into the array
// ST_IGNORE | unknown command, consume bits until CS rises
module tm_spi_sram_target #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              busy,
  output logic              cmd_err
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [7:0]        CMD_READ  = 8'h03;
  localparam logic [7:0]        CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADRH, ST_ADRL, ST_RDATA, ST_WDATA, ST_IGNORE
  } state_e;

  state_e state_q, state_d;

  // [0]/[1] are synchroniser stages, [2] holds the previous synchronised value
  logic [2:0] sck_q;
  logic [2:0] cs_n_q;
  logic [1:0] mosi_q;

  logic [2:0]        bit_cnt_q;
  logic [7:0]        shift_in_q;
  logic [7:0]        shift_out_q;
  logic              rd_q;
  logic [ADDR_W-9:0] adrh_q;
  logic [ADDR_W-1:0] addr_q;
  logic              miso_q;
  logic              cmd_err_q;
  logic [7:0]        host_rdata_q;
  logic [7:0]        mem_q [DEPTH];

  logic              cs_hi, cs_fall, sck_rise, sck_fall, mosi_s;
  logic [7:0]        byte_in;
  logic [ADDR_W-1:0] addr_new;
  logic              byte_done;
  logic              cmd_err_d, ld_first, wr_en, rd_next, rd_shift, oe_d;

  assign cs_hi    = cs_n_q[1];
  assign cs_fall  = ~cs_n_q[1] & cs_n_q[2];
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign mosi_s   = mosi_q[1];
  assign byte_in  = {shift_in_q[6:0], mosi_s};
  assign addr_new = {adrh_q, byte_in};

  // A byte completes on the rising SCK edge that wraps the counter from 7;
  // a CS rise in the same cycle wins and the byte is discarded.
  assign byte_done = ~cs_hi & (state_q != ST_IDLE) & sck_rise & (bit_cnt_q == 3'd7);

  // Input synchronisers; CS resets to inactive so busy is low out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_q  <= '0;
      cs_n_q <= '1;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], spi_sck};
      cs_n_q <= {cs_n_q[1:0], spi_cs_n};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic; inactive CS forces IDLE from anywhere
  always_comb begin
    state_d = state_q;
    if (cs_hi) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall) state_d = ST_CMD;
        ST_CMD: begin
          if (byte_done) begin
            if (byte_in == CMD_READ || byte_in == CMD_WRITE) state_d = ST_ADRH;
            else                                             state_d = ST_IGNORE;
          end
        end
        ST_ADRH: if (byte_done) state_d = ST_ADRL;
        ST_ADRL: if (byte_done) state_d = rd_q ? ST_RDATA : ST_WDATA;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs: per-cycle strobes for the datapath
  always_comb begin
    cmd_err_d = (state_q == ST_CMD) & byte_done &
                (byte_in != CMD_READ) & (byte_in != CMD_WRITE);
    ld_first  = (state_q == ST_ADRL) & byte_done & rd_q;
    wr_en     = (state_q == ST_WDATA) & byte_done;
    rd_shift  = (state_q == ST_RDATA) & ~cs_hi & sck_fall;
    rd_next   = rd_shift & (bit_cnt_q == 3'd7);
    oe_d      = (state_q == ST_RDATA);
  end

  // Bit counter and MOSI shifter; a CS fall restarts the count before any
  // coincident rising SCK edge is counted as the first command bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q  <= '0;
      shift_in_q <= '0;
    end else if (cs_hi) begin
      bit_cnt_q  <= '0;
      shift_in_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (cs_fall && sck_rise) begin
        bit_cnt_q  <= 3'd1;
        shift_in_q <= {7'd0, mosi_s};
      end else begin
        bit_cnt_q  <= '0;
        shift_in_q <= '0;
      end
    end else if (sck_rise) begin
      bit_cnt_q  <= bit_cnt_q + 3'd1;
      shift_in_q <= byte_in;
    end
  end

  // Command direction, address capture and auto-increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q   <= 1'b0;
      adrh_q <= '0;
      addr_q <= '0;
    end else begin
      if (state_q == ST_CMD && byte_done) rd_q <= (byte_in == CMD_READ);
      if (state_q == ST_ADRH && byte_done) adrh_q <= byte_in[ADDR_W-9:0];
      if (state_q == ST_ADRL && byte_done) addr_q <= rd_q ? addr_new + ADDR_ONE : addr_new;
      else if (wr_en || rd_next)           addr_q <= addr_q + ADDR_ONE;
    end
  end

  // Read shifter: bit 7 leaves on the first falling edge after the load, and
  // the 8th falling edge of each byte reloads the next array byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_out_q <= '0;
      miso_q      <= 1'b0;
    end else begin
      if (ld_first)      shift_out_q <= mem_q[addr_new];
      else if (rd_next)  shift_out_q <= mem_q[addr_q];
      else if (rd_shift) shift_out_q <= {shift_out_q[6:0], 1'b0};

      if (cs_hi || state_q != ST_RDATA) miso_q <= 1'b0;
      else if (rd_shift)                miso_q <= shift_out_q[7];
    end
  end

  // Registered status pulse and host read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_err_q    <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      cmd_err_q    <= cmd_err_d;
      host_rdata_q <= mem_q[host_addr];
    end
  end

  // Array write port: SPI owns it while busy, host writes only when idle
  always_ff @(posedge clk) begin
    if (wr_en)                 mem_q[addr_q]    <= byte_in;
    else if (host_we && cs_hi) mem_q[host_addr] <= host_wdata;
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_d;
  assign busy        = ~cs_n_q[1];
  assign cmd_err     = cmd_err_q;
  assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_tm_spi_sram_target.sv
// Directed bench for tm_spi_sram_target: an array model plus per-transaction
// expectations derived from the command/address/data rules, a per-cycle
// compare process, and literal values pinning the model.
module tb_tm_spi_sram_target;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              spi_sck = 1'b0;
  logic              spi_cs_n = 1'b1;
  logic              spi_mosi = 1'b0;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic              host_we = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [7:0]        host_wdata = '0;
  logic [7:0]        host_rdata;
  logic              busy;
  logic              cmd_err;

  tm_spi_sram_target #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .busy        (busy),
    .cmd_err     (cmd_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err = 0;
  logic [7:0]  model_mem [DEPTH];
  logic [2:0]  cs_hist = 3'b111;
  logic [ADDR_W-1:0] haddr_q = '0;
  logic        host_chk = 1'b0;
  int          cmd_err_seen = 0;
  logic [7:0]  txb [8];
  logic [7:0]  rxb [8];
  logic        oe_any_b [8];
  logic        oe_all_b [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bench view of what the DUT has seen: CS and host address per clock
  always @(posedge clk) begin
    cs_hist <= rst ? 3'b111 : {cs_hist[1:0], spi_cs_n};
    haddr_q <= host_addr;
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_err) cmd_err_seen++;
      chk("busy", {31'd0, busy}, {31'd0, !cs_hist[1]});
      if (cs_hist == 3'b111) begin
        chk("idle_oe", {31'd0, spi_miso_oe}, 32'd0);
        chk("idle_miso", {31'd0, spi_miso}, 32'd0);
        chk("idle_cmd_err", {31'd0, cmd_err}, 32'd0);
      end
      if (host_chk) chk("host_rdata", {24'd0, host_rdata}, {24'd0, model_mem[haddr_q]});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                      output logic oe_any, output logic oe_all);
    rx = '0; oe_any = 1'b0; oe_all = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      half();
      rx = {rx[6:0], spi_miso};
      oe_any = oe_any | spi_miso_oe;
      oe_all = oe_all & spi_miso_oe;
      spi_sck = 1'b1;
      half();
      spi_sck = 1'b0;
    end
  endtask

  // One CS-framed transaction of nbytes full bytes plus extra_bits trailing bits,
  // followed by model-derived checks and the model array update
  task automatic do_txn(input int nbytes, input int extra_bits);
    logic [7:0] rx;
    logic oa, ol, is_rd, is_wr;
    int base;
    host_chk = 1'b0;
    cmd_err_seen = 0;
    spi_cs_n = 1'b0;
    half();
    for (int b = 0; b < nbytes; b++) begin
      xfer(txb[b], 8, rx, oa, ol);
      rxb[b] = rx; oe_any_b[b] = oa; oe_all_b[b] = ol;
    end
    if (extra_bits > 0) xfer(txb[nbytes], extra_bits, rx, oa, ol);
    half();
    spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("busy_drop", {31'd0, busy}, 32'd0);
    is_rd = (nbytes >= 1) && (txb[0] == 8'h03);
    is_wr = (nbytes >= 1) && (txb[0] == 8'h02);
    base  = ({txb[1], txb[2]}) % DEPTH;
    chk("cmd_err_pulses", cmd_err_seen, (nbytes >= 1 && !is_rd && !is_wr) ? 32'd1 : 32'd0);
    for (int b = 0; b < nbytes; b++) begin
      if (is_rd && b >= 3) begin
        chk("rd_data", {24'd0, rxb[b]}, {24'd0, model_mem[(base + b - 3) % DEPTH]});
        chk("oe_data", {31'd0, oe_all_b[b]}, 32'd1);
      end else begin
        chk("miso_quiet", {24'd0, rxb[b]}, 32'd0);
        chk("oe_off", {31'd0, oe_any_b[b]}, 32'd0);
      end
    end
    if (is_wr) for (int b = 3; b < nbytes; b++) model_mem[(base + b - 3) % DEPTH] = txb[b];
    @(negedge clk);
    host_chk = 1'b1;
  endtask

  task automatic peek(input string name, input logic [ADDR_W-1:0] a, input logic [7:0] exp);
    host_addr = a;
    @(negedge clk);
    chk(name, {24'd0, host_rdata}, {24'd0, exp});
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [7:0] d, input logic accepted);
    host_chk = 1'b0;
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
    if (accepted) model_mem[a] = d;
    repeat (2) @(negedge clk);
    host_chk = 1'b1;
  endtask

  initial begin
    logic [7:0] rx;
    logic oa, ol;

    repeat (3) @(negedge clk);
    chk("rst_miso", {31'd0, spi_miso}, 32'd0);
    chk("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
    chk("rst_host_rdata", {24'd0, host_rdata}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // preload every location through the host port
    for (int i = 0; i < DEPTH; i++) begin
      host_we = 1'b1; host_addr = ADDR_W'(i); host_wdata = 8'((i * 7 + 3) & 255);
      model_mem[i] = 8'((i * 7 + 3) & 255);
      @(negedge clk);
    end
    host_we = 1'b0;
    host_addr = 10'h010;
    repeat (2) @(negedge clk);
    host_chk = 1'b1;

    // write two bytes, then stream them back
    txb[0] = 8'h02; txb[1] = 8'h00; txb[2] = 8'h10; txb[3] = 8'hAB; txb[4] = 8'hCD;
    do_txn(5, 0);
    peek("wr_0x010", 10'h010, 8'hAB);
    peek("wr_0x011", 10'h011, 8'hCD);
    txb[0] = 8'h03; txb[3] = 8'h00; txb[4] = 8'h00;
    do_txn(5, 0);
    chk("rd_lit0", {24'd0, rxb[3]}, 32'hAB);
    chk("rd_lit1", {24'd0, rxb[4]}, 32'hCD);

    // address wrap with upper address bits ignored, write then read
    txb[0] = 8'h02; txb[1] = 8'hFF; txb[2] = 8'hFF; txb[3] = 8'h11; txb[4] = 8'h22;
    do_txn(5, 0);
    peek("wrap_0x3ff", 10'h3FF, 8'h11);
    peek("wrap_0x000", 10'h000, 8'h22);
    txb[0] = 8'h03; txb[1] = 8'h03; txb[2] = 8'hFF; txb[3] = 8'h00; txb[4] = 8'h00;
    do_txn(5, 0);
    chk("rd_wrap0", {24'd0, rxb[3]}, 32'h11);
    chk("rd_wrap1", {24'd0, rxb[4]}, 32'h22);

    // partial byte is dropped on CS rise
    txb[0] = 8'h02; txb[1] = 8'h00; txb[2] = 8'h20; txb[3] = 8'h99;
    do_txn(3, 5);
    peek("partial_0x020", 10'h020, 8'hE3);
    txb[0] = 8'h03; txb[3] = 8'h00;
    do_txn(4, 0);
    chk("partial_rd", {24'd0, rxb[3]}, 32'hE3);

    // unknown command
    txb[0] = 8'h05; txb[1] = 8'h12; txb[2] = 8'h34; txb[3] = 8'h56;
    do_txn(4, 0);
    chk("bad_cmd_pulse", cmd_err_seen, 32'd1);
    peek("bad_cmd_0x234", 10'h234, 8'h6F);

    // host writes: accepted when idle, dropped while CS is low
    host_write(10'h041, 8'h5A, 1'b1);
    peek("host_wr_idle", 10'h041, 8'h5A);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_cs_low", {31'd0, busy}, 32'd1);
    host_write(10'h040, 8'h77, 1'b0);
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    peek("host_wr_busy", 10'h040, 8'hC3);

    // reset in the middle of a read stream
    host_chk = 1'b0;
    spi_cs_n = 1'b0;
    half();
    xfer(8'h03, 8, rx, oa, ol);
    xfer(8'h00, 8, rx, oa, ol);
    xfer(8'h10, 8, rx, oa, ol);
    xfer(8'h00, 2, rx, oa, ol);
    chk("mid_rd_bits", {24'd0, rx}, 32'h02);
    repeat (4) @(negedge clk);
    chk("mid_rd_oe", {31'd0, spi_miso_oe}, 32'd1);
    chk("mid_rd_miso", {31'd0, spi_miso}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_miso", {31'd0, spi_miso}, 32'd0);
    chk("rst_mid_oe", {31'd0, spi_miso_oe}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    host_chk = 1'b1;
    txb[0] = 8'h03; txb[1] = 8'h00; txb[2] = 8'h10; txb[3] = 8'h00; txb[4] = 8'h00;
    do_txn(5, 0);
    chk("post_rst_rd0", {24'd0, rxb[3]}, 32'hAB);
    chk("post_rst_rd1", {24'd0, rxb[4]}, 32'hCD);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
